serial_alu_ctrl: RTL and testbench
==================================

SERIAL_ALU_CTRL -- requirements
Module: serial_alu_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 SHALL have port a  input  WIDTH  operand A; latched on accepted start.
REQ-006 SHALL have port b  input  WIDTH  operand B; latched on accepted start.
REQ-007 SHALL have port op  input  3  operation code; latched on accepted start.
REQ-008 SHALL have port result  output  WIDTH  registered result.
REQ-009 SHALL have port cout  output  1  carry out of the MSB.
REQ-010 SHALL have port overflow  output  1  signed overflow flag.
REQ-011 SHALL have port zero  output  1  high when result is all zeros.
REQ-012 SHALL have port busy  output  1  high while in RUN.
REQ-013 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-014 SHALL decode op as follows: op[2] = binvert (b inverted per bit, initial carry-in = op[2]); op[1:0] 00 AND, 01 OR, 10 ADD, 11 SLT.
REQ-015 SHALL therefore implement 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT, 100 a&~b, 101 a|~b, 011 SLT without invert (sign of a+b+0).
REQ-016 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-017 SHALL, in IDLE with start=1 at an edge, latch a, b, op, load carry with op[2], clear the bit index, and enter RUN.
REQ-018 SHALL, in RUN, process exactly one bit per edge, LSB first (index 0..WIDTH-1), through a one-bit slice: AND, OR, or sum = ai ^ bi' ^ c; next c = majority(ai, bi', c).
REQ-019 SHALL shift each computed bit into its result position; partial results are not visible on result until DONE.
REQ-020 SHALL, on the edge processing index WIDTH-1, enter DONE and update result/cout/overflow/zero.
REQ-021 SHALL, for SLT, set result = {WIDTH-1 zeros, set}, where set is the MSB sum bit (no overflow correction).
REQ-022 SHALL drive cout = carry out of the MSB for ADD/SLT codes and 0 for AND/OR codes.
REQ-023 SHALL drive overflow = (carry into MSB) XOR (carry out of MSB) for op[1:0]=10 and 0 otherwise.
REQ-024 SHALL drive zero = (result == 0), updated together with result.
REQ-025 SHALL hold done=1 for exactly the single DONE cycle, then return to IDLE; busy=0 in DONE.
REQ-026 SHALL assert done WIDTH edges after the edge that accepted start (8 for WIDTH=8).
REQ-027 SHALL ignore start in RUN and DONE; a held start is accepted on the first IDLE edge after DONE.
REQ-028 SHALL hold result/cout/overflow/zero stable from DONE until the next completion; operand changes after acceptance SHALL have no effect.

Reset
REQ-029 SHALL, when rst=1 asynchronously, force state IDLE and drive result=0, cout=0, overflow=0, zero=0, busy=0, done=0, clearing internal carry/index.
REQ-030 SHALL abort an in-progress RUN on reset with no done pulse; start is not accepted while rst=1.

Verification
REQ-031 SHALL pass: ADD op=010, a=8'h35, b=8'h4A -> result=8'h7F, cout=0, overflow=0, zero=0, done 8 edges after start.
REQ-032 SHALL pass: SUB op=110, a=8'h10, b=8'h20 -> result=8'hF0, cout=0, overflow=0; a=8'h20, b=8'h20 -> 8'h00, zero=1, cout=1.
REQ-033 SHALL pass: ADD 8'h7F+8'h01 -> result=8'h80, overflow=1, cout=0; ADD 8'hFF+8'h01 -> 8'h00, cout=1, zero=1, overflow=0.
REQ-034 SHALL pass: SLT op=111, a=3, b=5 -> 8'h01; a=5, b=3 -> 8'h00, zero=1; AND 000 8'hF0&8'h3C -> 8'h30; op=101 a=8'h00, b=8'hFF -> 8'h00.
REQ-035 SHALL pass: start pulsed again during RUN -> ignored, single done; start held high -> back-to-back ops with one IDLE cycle between done and next busy.
REQ-036 SHALL pass: rst asserted mid-RUN (after 4 bits) -> all outputs 0 immediately, no done; next start completes normally.

Source files
------------

// File: rtl/serial_alu_ctrl.sv
// -----------------------------------------------------------------------------
// serial_alu_ctrl
//   Bit-serial ALU. An accepted start latches the operands and the op code.
//   One bit is then processed per clock, LSB first, through a one-bit ALU
//   slice. The registered result and flags update together when the last bit
//   completes, and a one-cycle done pulse marks that update.
//
//   op[2]   : binvert. B is inverted per bit and the initial carry-in = op[2].
//   op[1:0] : 00 AND, 01 OR, 10 ADD, 11 SLT (set = MSB sum bit).
//
// Ports
//   clk         in   clock, rising edge
//   rst         in   asynchronous active-high reset
//   start       in   request; accepted only in IDLE
//   a, b        in   WIDTH-bit operands, latched when start is accepted
//   op          in   3-bit operation code, latched when start is accepted
//   result      out  registered WIDTH-bit result
//   cout        out  carry out of the MSB (ADD/SLT codes), else 0
//   overflow    out  signed overflow (op[1:0]=10), else 0
//   zero        out  result == 0
//   busy        out  high while in RUN
//   done        out  one-cycle completion pulse (the DONE state)
//   dbg_state_o out  current FSM state (0 IDLE, 1 RUN, 2 DONE)
//
// Handshake: start is sampled at a rising edge only while the FSM is in IDLE,
// which means busy=0 and done=0. A start that is seen in RUN or DONE is
// dropped rather than queued. A start that is held high is therefore accepted
// at the first IDLE edge after DONE.
// -----------------------------------------------------------------------------
module serial_alu_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic [1:0]       dbg_state_o
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic             carry_q, carry_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    // One-bit ALU slice
    logic             ai, bi, sum_bit, carry_next, slice_bit;
    logic [WIDTH-1:0] built;
    logic [WIDTH-1:0] final_res;

    always_comb begin
        ai         = a_q[idx_q];
        bi         = b_q[idx_q] ^ op_q[2];
        sum_bit    = ai ^ bi ^ carry_q;
        carry_next = (ai & bi) | (ai & carry_q) | (bi & carry_q);
        case (op_q[1:0])
            2'b00:   slice_bit = ai & bi;
            2'b01:   slice_bit = ai | bi;
            default: slice_bit = sum_bit;
        endcase
        // The partial result stays internal. It reaches the result register
        // only when the last bit completes.
        built        = shift_q;
        built[idx_q] = slice_bit;
        // SLT reports only the raw MSB sum bit. No overflow correction is
        // applied to it.
        if (op_q[1:0] == 2'b11) begin
            final_res = {{(WIDTH-1){1'b0}}, sum_bit};
        end else begin
            final_res = built;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        carry_d  = carry_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = op;
                    carry_d = op[2];
                    idx_d   = '0;
                    shift_d = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                carry_d = carry_next;
                shift_d = built;
                if (idx_q == LAST_IDX) begin
                    idx_d    = '0;
                    state_d  = S_DONE;
                    result_d = final_res;
                    zero_d   = (final_res == '0);
                    cout_d   = op_q[1] ? carry_next : 1'b0;
                    // The carry into the MSB is the carry register value
                    // before the MSB slice adds to it.
                    ovf_d    = (op_q[1:0] == 2'b10) ? (carry_q ^ carry_next) : 1'b0;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            shift_q  <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            carry_q  <= carry_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign result      = result_q;
    assign cout        = cout_q;
    assign overflow    = ovf_q;
    assign zero        = zero_q;
    assign busy        = (state_q == S_RUN);
    assign done        = (state_q == S_DONE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_serial_alu_ctrl.sv
module tb_serial_alu_ctrl;

  localparam int WIDTH = 8;
  localparam int EW = WIDTH + 3;  // {result, cout, overflow, zero}

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             start;
  logic [WIDTH-1:0] a, b;
  logic [2:0]       op;
  logic [WIDTH-1:0] result;
  logic             cout, overflow, zero, busy, done;
  logic [1:0]       dbg_state;

  serial_alu_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .a(a),
    .b(b),
    .op(op),
    .result(result),
    .cout(cout),
    .overflow(overflow),
    .zero(zero),
    .busy(busy),
    .done(done),
    .dbg_state_o(dbg_state)
  );

  // scoreboard
  logic [EW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_fail = 0;
  int done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // monitor: pops on every done pulse
  always @(negedge clk) begin
    if (!rst && done) begin
      logic [EW-1:0] e;
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("result_flags", 32'({result, cout, overflow, zero}), 32'(e));
      end
    end
  end

  // driver tasks: called at posedge+1 while the DUT is in IDLE
  task automatic push_exp(input logic [7:0] er, input logic ec, input logic eo);
    exp_q.push_back({er, ec, eo, (er == 8'h00)});
  endtask

  task automatic do_op(input string name, input logic [7:0] ta, input logic [7:0] tb,
                       input logic [2:0] top, input logic [7:0] er,
                       input logic ec, input logic eo);
    int lat;
    bit seen;
    push_exp(er, ec, eo);
    a = ta; b = tb; op = top; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // operand changes after acceptance must not matter
    a = 8'($urandom_range(0, 255));
    b = 8'($urandom_range(0, 255));
    op = 3'($urandom_range(0, 7));
    check({name, "_busy"}, 32'(busy), 32'd1);
    lat = 0; seen = 0;
    while (!seen && lat < 40) begin
      @(posedge clk); lat++; #1;
      if (done) seen = 1;
    end
    check({name, "_latency"}, seen ? lat : 999, 32'd8);
    @(posedge clk); #1;
    check({name, "_idle_after"}, 32'({done, busy}), 32'd0);
  endtask

  initial begin
    int dc0;
    int guard;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; op = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 32'({result, cout, overflow, zero, busy, done}), 32'd0);
    check("reset_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // directed vectors
    do_op("add_35_4a",   8'h35, 8'h4A, 3'b010, 8'h7F, 1'b0, 1'b0);
    do_op("sub_10_20",   8'h10, 8'h20, 3'b110, 8'hF0, 1'b0, 1'b0);
    do_op("sub_20_20",   8'h20, 8'h20, 3'b110, 8'h00, 1'b1, 1'b0);
    do_op("add_7f_01",   8'h7F, 8'h01, 3'b010, 8'h80, 1'b0, 1'b1);
    do_op("add_ff_01",   8'hFF, 8'h01, 3'b010, 8'h00, 1'b1, 1'b0);
    do_op("slt_3_5",     8'h03, 8'h05, 3'b111, 8'h01, 1'b0, 1'b0);
    do_op("slt_5_3",     8'h05, 8'h03, 3'b111, 8'h00, 1'b1, 1'b0);
    do_op("and_f0_3c",   8'hF0, 8'h3C, 3'b000, 8'h30, 1'b0, 1'b0);
    do_op("ornb_00_ff",  8'h00, 8'hFF, 3'b101, 8'h00, 1'b0, 1'b0);
    do_op("andnb_ff_0f", 8'hFF, 8'h0F, 3'b100, 8'hF0, 1'b0, 1'b0);
    do_op("or_a5_0f",    8'hA5, 8'h0F, 3'b001, 8'hAF, 1'b0, 1'b0);
    do_op("sltni_70_20", 8'h70, 8'h20, 3'b011, 8'h01, 1'b0, 1'b0);

    // start pulsed again during RUN -> single done
    dc0 = done_cnt;
    push_exp(8'h0F, 1'b1, 1'b0);  // 0x10 - 0x01
    a = 8'h10; b = 8'h01; op = 3'b110; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("repulse_single_done", done_cnt - dc0, 32'd1);
    check("repulse_idle", 32'(busy), 32'd0);

    // start held high -> back-to-back, one IDLE cycle between
    push_exp(8'h7F, 1'b0, 1'b0);
    push_exp(8'h7F, 1'b0, 1'b0);
    a = 8'h35; b = 8'h4A; op = 3'b010; start = 1'b1;
    guard = 0;
    while (!done && guard < 40) begin @(posedge clk); guard++; #1; end
    check("b2b_first_done", 32'(done), 32'd1);
    @(posedge clk); #1;
    check("b2b_idle_gap", 32'({busy, done}), 32'd0);
    @(posedge clk); #1;
    check("b2b_second_busy", 32'(busy), 32'd1);
    start = 1'b0;
    guard = 0;
    while (!done && guard < 40) begin @(posedge clk); guard++; #1; end
    check("b2b_second_done", 32'(done), 32'd1);
    @(posedge clk); #1;

    // reset mid-RUN after 4 bits (no expectation pushed: a done here is wrong)
    dc0 = done_cnt;
    a = 8'h12; b = 8'h34; op = 3'b010; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1; start = 1'b1;
    #1;
    check("abort_outputs", 32'({result, cout, overflow, zero, busy, done}), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_start_in_rst", 32'(dbg_state), 32'd0);
    start = 1'b0; rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt - dc0, 32'd0);
    do_op("after_abort", 8'h01, 8'h02, 3'b010, 8'h03, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
